// File: rtl/byte_fifo_arb_pkg.sv
// Shared types for the byte FIFO arbiter.
// Holds the FSM state encoding and the default requester count.
package byte_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/byte_fifo_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr.
// Wraps modulo N; found is low when no request is set.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_fifo_arbiter.sv
// Packet-granular round-robin arbiter feeding one byte FIFO write port.
// Holds a grant for a whole packet; revokes it after TIMEOUT idle cycles.
module byte_fifo_arbiter
    import byte_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_write_enable,
    output logic [7:0]                 fifo_write_data,
    input  logic [11:0]                fifo_slots_free,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [CW-1:0] idle_cnt;
    logic          room;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          accept;
    logic          stall;
    logic [IW-1:0] next_ptr;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign room     = fifo_slots_free >= 12'(GUARD);
    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];
    assign g_data   = req_data[{grant_id, 3'b000} +: 8];
    assign accept   = (state == ST_BURST) && room && g_valid && !reset;
    assign stall    = g_valid && !room;
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == ST_BURST && room && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            idle_cnt          <= '0;
            fifo_write_enable <= 1'b0;
            fifo_write_data   <= '0;
            timeout_err       <= '0;
            busy              <= 1'b0;
        end else begin
            fifo_write_enable <= accept;
            if (accept) begin
                fifo_write_data <= g_data;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        idle_cnt <= '0;
                        state    <= ST_BURST;
                        busy     <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (g_last) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!stall) begin
                        // FIFO-full stalls are not the requester's fault
                        if (idle_cnt == CW'(TIMEOUT - 1)) begin
                            timeout_err[grant_id] <= 1'b1;
                            idle_cnt              <= '0;
                            state                 <= ST_IDLE;
                            busy                  <= 1'b0;
                            rr_ptr                <= next_ptr;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
